// File: rtl/sphere_pair_scheduler.sv
// sphere_pair_scheduler: loads the sphere-pair RAM from a host word stream and
// then hands each 8-word record (sphere A x,y,z,r; sphere B x,y,z,r) to the
// dCollideSpheres core one at a time using a start/done handshake.
// Optional feature macro: SCHED_TIMEOUT_EN adds a core watchdog that counts
// cycles in WAIT. When TIMEOUT cycles pass without core_done, the record is
// skipped and err is raised.
module sphere_pair_scheduler #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr_in,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  core_start,
  input  logic                  core_done,
  output logic [ADDR_WIDTH-1:0] pair_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] DEPTH     = ADDR_WIDTH'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] FULL_RECS = ADDR_WIDTH'(RAM_DEPTH / 8);

  logic [2:0]            state;
  logic [2:0]            state_nx;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic [ADDR_WIDTH-1:0] rec_cnt;
  logic [ADDR_WIDTH-1:0] n_rec;
  logic                  done_r;
  logic                  err_r;

  logic [ADDR_WIDTH-1:0] wr_next;
  logic [ADDR_WIDTH-1:0] rec_next;
  logic [ADDR_WIDTH-1:0] load_nrec;
  logic                  accept;
  logic                  overflow;
  logic                  load_end;
  logic                  partial;
  logic                  pair_done;
  logic                  timeout_hit;
  logic                  enter_load;
  logic                  ram_reading;

  assign wr_next  = wr_cnt + 1'b1;
  assign rec_next = rec_cnt + 1'b1;

  // Host side: a word is taken while the RAM still has room. Words offered
  // after the RAM is full are dropped, but their in_last still ends the load.
  assign in_ready = (state == S_LOAD) && (wr_cnt < DEPTH);
  assign accept   = in_valid & in_ready;
  assign overflow = (state == S_LOAD) && in_valid && (wr_cnt == DEPTH);
  assign load_end = (accept | overflow) & in_last;

  // A load that stops inside a record leaves a partial record. Only whole
  // records are counted, so the trailing partial record is dropped.
  assign load_nrec = accept ? (wr_next >> 3) : FULL_RECS;
  assign partial   = accept && (wr_next[2:0] != 3'd0);

  assign pair_done  = (state == S_WAIT) && (core_done || timeout_hit);
  assign enter_load = (state_nx == S_LOAD) && (state != S_LOAD);

`ifdef SCHED_TIMEOUT_EN
  logic [31:0] wd_cnt;

  // Watchdog: counts cycles spent in WAIT and restarts for every record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state != S_WAIT) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == S_WAIT) && !core_done && (wd_cnt == 32'(TIMEOUT - 1));
`else
  logic timeout_unused;

  assign timeout_hit    = 1'b0;
  assign timeout_unused = (TIMEOUT != 0);
`endif

  // Next-state selection for the load/run sequencer.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = S_LOAD;
      S_LOAD: begin
        if (load_end) begin
          state_nx = (load_nrec == '0) ? S_DONE : S_RD;
        end
      end
      S_RD:    state_nx = S_START;
      S_START: state_nx = S_WAIT;
      S_WAIT: begin
        if (pair_done) begin
          state_nx = (rec_next == n_rec) ? S_DONE : S_RD;
        end
      end
      S_DONE: begin
        if (in_valid) begin
          state_nx = S_LOAD;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Write pointer: restarts with each load and advances once per stored word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
    end else if (enter_load) begin
      wr_cnt <= '0;
    end else if (accept) begin
      wr_cnt <= wr_next;
    end
  end

  // Record bookkeeping: the count of whole records loaded and the record under test.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_cnt <= '0;
      n_rec   <= '0;
    end else begin
      if (enter_load) begin
        rec_cnt <= '0;
      end else if (pair_done) begin
        rec_cnt <= rec_next;
      end
      if (load_end) begin
        n_rec <= load_nrec;
      end
    end
  end

  // Status flags: done holds until the next load, and err is sticky until then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else if (enter_load) begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      if (state_nx == S_DONE) begin
        done_r <= 1'b1;
      end
      if (overflow || (load_end && partial) || timeout_hit) begin
        err_r <= 1'b1;
      end
    end
  end

  // RAM stays enabled from RD through WAIT so its tri-stated outputs keep
  // driving the core. The write strobe is gated by rst, so a write in flight
  // is dropped as soon as reset rises.
  assign ram_reading  = (state == S_RD) || (state == S_START) || (state == S_WAIT);
  assign ram_we       = accept & ~rst;
  assign ram_oe       = ram_reading;
  assign ram_cs       = ram_we | ram_reading;
  assign ram_addr_in  = wr_cnt;
  assign ram_addr_out = rec_cnt << 3;
  assign ram_din      = (state == S_LOAD) ? in_data : '0;

  assign core_start = (state == S_START);
  assign pair_idx   = rec_cnt;
  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign done       = done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_sphere_pair_scheduler.sv
// tb_sphere_pair_scheduler: table-driven and randomized checks of the sphere-pair
// scheduler. A word-level RAM model and a modelled collision core are kept in
// the bench. The SCHED_TIMEOUT_EN sequence is built only when that macro is set.
module tb_sphere_pair_scheduler;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int TMO   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          ram_cs;
  logic          ram_we;
  logic          ram_oe;
  logic [AW-1:0] ram_addr_in;
  logic [AW-1:0] ram_addr_out;
  logic [DW-1:0] ram_din;
  logic          core_start;
  logic          core_done;
  logic [AW-1:0] pair_idx;
  logic          busy;
  logic          done;
  logic          err;

  logic resp_done  = 1'b0;
  logic stray_done = 1'b0;
  assign core_done = resp_done | stray_done;

  sphere_pair_scheduler #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_addr_in(ram_addr_in), .ram_addr_out(ram_addr_out), .ram_din(ram_din),
    .core_start(core_start), .core_done(core_done), .pair_idx(pair_idx),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n_words;
    int delay;
    bit exp_err;
    int exp_nrec;
  } vec_t;

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [DW-1:0] ram_model [DEPTH];
  bit            ram_written [DEPTH];
  int            wr_seen = 0;
  logic [DW-1:0] wdata [64];
  int            start_idx [$];
  int            start_addr [$];
  int            resp_delay = 1;
  bit            resp_en = 1'b1;
  bit            resp_kill = 1'b0;
  int            cur_nrec = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Word-level RAM model: captures every write and checks the write/read strobes.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we === 1'b1) begin
        wr_seen++;
        checkOutput("write_in_range", 32'(ram_addr_in < DEPTH), 32'd1);
        if (ram_addr_in < DEPTH) begin
          ram_model[ram_addr_in[4:0]] = ram_din;
          ram_written[ram_addr_in[4:0]] = 1'b1;
        end
      end
      if (ram_we === 1'b1 || ram_oe === 1'b1) begin
        checkOutput("we_oe_exclusive", 32'(ram_we & ram_oe), 32'd0);
      end
    end
  end

  // Collision core model: records each start, then answers after resp_delay cycles.
  initial begin : core_model
    bit killed;
    int idx;
    forever begin
      @(negedge clk);
      if (core_start === 1'b1) begin
        idx = int'(pair_idx);
        start_idx.push_back(idx);
        start_addr.push_back(int'(ram_addr_out));
        checkOutput("start_ram_cs_oe_we", 32'({ram_cs, ram_oe, ram_we}), 32'b110);
        if (resp_en) begin
          killed = 1'b0;
          resp_kill = 1'b0;
          for (int d = 0; d < resp_delay; d++) begin
            @(negedge clk);
            if (resp_kill) begin
              killed = 1'b1;
              break;
            end
          end
          if (!killed) begin
            resp_done = 1'b1;
            @(negedge clk);
            resp_done = 1'b0;
            if (idx + 1 < cur_nrec) begin
              checkOutput("next_rd_addr", ram_addr_out, 32'((idx + 1) * 8));
              checkOutput("next_rd_oe_nostart", 32'({ram_oe, core_start}), 32'b10);
            end else begin
              checkOutput("done_after_last", 32'(done), 32'd1);
            end
          end
        end
      end
    end
  end

  // Behavioural reference: whole records among the stored words; any spill or partial sets err.
  function automatic void model(input int n, output int nrec, output bit e);
    if (n > DEPTH) begin
      nrec = DEPTH / 8;
      e    = 1'b1;
    end else begin
      nrec = n / 8;
      e    = (n % 8) != 0;
    end
  endfunction

  // Streams n random words, one per cycle once the scheduler opens for a load.
  task automatic applyStimulus(input int n);
    int budget;
    for (int i = 0; i < n; i++) wdata[i] = $urandom;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = wdata[0];
    in_last  = (n == 1);
    budget   = 0;
    while (in_ready !== 1'b1 && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    checkOutput("load_handshake", 32'(in_ready), 32'd1);
    for (int i = 0; i < n; i++) begin
      in_data    = wdata[i];
      in_last    = (i == n - 1);
      stray_done = 1'($urandom_range(0, 1));
      checkOutput("in_ready_word", 32'(in_ready), 32'(i < DEPTH));
      @(posedge clk); #1;
    end
    in_valid   = 1'b0;
    in_last    = 1'b0;
    stray_done = 1'b0;
  endtask

  task automatic waitDone();
    int c = 0;
    while (done !== 1'b1 && c < 4000) begin
      @(negedge clk);
      c++;
    end
    checkOutput("done_reached", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic prepScenario(input int dly, input int nrec);
    for (int k = 0; k < DEPTH; k++) ram_written[k] = 1'b0;
    wr_seen = 0;
    start_idx.delete();
    start_addr.delete();
    resp_delay = dly;
    cur_nrec = nrec;
  endtask

  task automatic runScenario(input string name, input int n, input int dly, input bit exp_err, input int exp_nrec);
    int written;
    int bad;
    prepScenario(dly, exp_nrec);
    applyStimulus(n);
    waitDone();
    checkOutput({name, "_err"}, 32'(err), 32'(exp_err));
    checkOutput({name, "_starts"}, 32'(start_idx.size()), 32'(exp_nrec));
    foreach (start_idx[k]) begin
      checkOutput({name, "_pair_idx"}, 32'(start_idx[k]), 32'(k));
      checkOutput({name, "_rd_addr"}, 32'(start_addr[k]), 32'(k * 8));
    end
    written = (n < DEPTH) ? n : DEPTH;
    checkOutput({name, "_writes"}, 32'(wr_seen), 32'(written));
    bad = 0;
    for (int k = 0; k < written; k++) begin
      if (!ram_written[k] || ram_model[k] !== wdata[k]) bad++;
    end
    checkOutput({name, "_ram_contents"}, 32'(bad), 32'd0);
    checkOutput({name, "_idle_flags"}, 32'({busy, in_ready, ram_cs, ram_oe}), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin : main
    vec_t vecs [9];
    int   nrec;
    bit   e;
    int   n;
    int   dly;
    int   cnt;

    vecs[0] = '{16, 1, 1'b0, 2};
    vecs[1] = '{10, 2, 1'b1, 1};
    vecs[2] = '{40, 1, 1'b1, 4};
    vecs[3] = '{8,  5, 1'b0, 1};
    vecs[4] = '{32, 3, 1'b0, 4};
    vecs[5] = '{33, 1, 1'b1, 4};
    vecs[6] = '{7,  2, 1'b1, 0};
    vecs[7] = '{24, 4, 1'b0, 3};
    vecs[8] = '{1,  1, 1'b1, 0};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 32'hdead_beef;
    in_last = 1'b0;
    #12;
    checkOutput("reset_outputs",
      32'({in_ready, ram_cs, ram_we, ram_oe, core_start, busy, done, err,
           |ram_addr_in, |ram_addr_out, |pair_idx, |ram_din}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("idle_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    checkOutput("load_open", 32'({in_ready, busy}), 32'b11);

    for (int v = 0; v < 9; v++) begin
      runScenario($sformatf("vec%0d", v), vecs[v].n_words, vecs[v].delay, vecs[v].exp_err, vecs[v].exp_nrec);
    end

    // Reset while record 1 is in WAIT, then a clean single-record reload.
    prepScenario(30, 2);
    applyStimulus(16);
    cnt = 0;
    while (start_idx.size() < 2 && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    repeat (3) @(negedge clk);
    checkOutput("rec1_waiting", 32'({busy, core_start, pair_idx[3:0]}), 32'b10_0001);
    #2;
    resp_kill = 1'b1;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_outputs",
      32'({in_ready, ram_cs, ram_we, ram_oe, core_start, busy, done, err,
           |ram_addr_in, |ram_addr_out, |pair_idx, |ram_din}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    runScenario("reload_after_rst", 8, 2, 1'b0, 1);

    // Randomized loads checked against the behavioural reference.
    for (int r = 0; r < 20; r++) begin
      n   = $urandom_range(1, 44);
      dly = $urandom_range(1, 6);
      model(n, nrec, e);
      runScenario($sformatf("rand%0d_n%0d", r, n), n, dly, e, nrec);
    end

`ifdef SCHED_TIMEOUT_EN
    // Core never answers: each record times out after TMO cycles in WAIT.
    resp_en = 1'b0;
    prepScenario(1, 2);
    applyStimulus(16);
    cnt = 0;
    while (core_start !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("tmo_first_start", 32'(core_start), 32'd1);
    checkOutput("tmo_err_before", 32'(err), 32'd0);
    cnt = 0;
    while (err !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    // TMO cycles in WAIT, then err is visible at the following sample.
    checkOutput("tmo_cycles", 32'(cnt), 32'(TMO + 1));
    waitDone();
    checkOutput("tmo_starts", 32'(start_idx.size()), 32'd2);
    if (start_idx.size() == 2) checkOutput("tmo_second_idx", 32'(start_idx[1]), 32'd1);
    checkOutput("tmo_err", 32'(err), 32'd1);
    resp_en = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
